counter_cmd_arbiter: RTL and testbench
======================================

Name: counter_cmd_arbiter

Overview:
- Merges the two command sources for the 10 Hz up/down counter into one ordered command stream: debounced front-panel button pulses and received UART bytes.
- Decodes ASCII UART bytes and arbitrates round-robin between the sources.
- Buffers accepted commands in a small FIFO and presents them to the counter control unit over a valid/ready handshake.
- Sits between the button debouncers / UART RX and the counter control unit.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high reset.
- btn_mode, in, 1, one-cycle debounced pulse.
- btn_run_stop, in, 1, one-cycle debounced pulse.
- btn_clear, in, 1, one-cycle debounced pulse.
- rx_data, in, 8, UART received byte.
- rx_valid, in, 1, one-cycle strobe qualifying rx_data.
- cmd_valid, out, 1, FIFO head valid.
- cmd_code, out, 3, command at FIFO head.
- cmd_src, out, 1, origin of head command: 0 = button, 1 = UART.
- cmd_ready, in, 1, consumer accepts the head command.
- fifo_level, out, $clog2(FIFO_DEPTH)+1, current occupancy.
- drop_cnt, out, DROP_W, saturating count of discarded inputs.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: cmd_valid=0, cmd_code=0, cmd_src=0, fifo_level=0, drop_cnt=0, all pending bits and the UART holding register empty, last_grant=UART.
- Command codes: 0 NOP (never issued), 1 MODE_TOGGLE, 2 RUN_TOGGLE, 3 RUN, 4 STOP, 5 CLEAR, 6 SET_UP, 7 SET_DOWN.
- Button source:
  - One pending bit per button, set on the pulse edge.
  - A pulse arriving while its bit is already set is coalesced and increments drop_cnt.
  - Bit-to-command mapping: btn_clear→CLEAR, btn_run_stop→RUN_TOGGLE, btn_mode→MODE_TOGGLE.
  - With several bits set, the button request uses fixed priority clear > run_stop > mode. Only the granted bit clears.
- UART source:
  - One-entry holding register, loaded on rx_valid with the decoded byte.
  - Decode: 'r'→RUN, 's'→STOP, 'c'→CLEAR, 'm'→MODE_TOGGLE, 'u'→SET_UP, 'd'→SET_DOWN.
  - Any other byte is discarded and increments drop_cnt; the holding register is unchanged.
  - rx_valid while the holding register is full discards the new byte and increments drop_cnt.
- Arbiter, evaluated each cycle:
  - If the FIFO is not full and at least one source is requesting, push one command.
  - Both sources requesting: grant the source not in last_grant, then update last_grant.
  - One source requesting: grant it; last_grant updates to that source.
  - FIFO full: no grant; requests hold and nothing is dropped.
- FIFO:
  - cmd_valid = level≠0; cmd_code and cmd_src come from the registered head.
  - Pop on cmd_valid&&cmd_ready.
  - Simultaneous push and pop when not full leaves the level unchanged.
  - When full, push is blocked even if a pop occurs in the same cycle; the push happens the next cycle.
  - cmd_code and cmd_src stay stable while cmd_valid=1 and cmd_ready=0.
- Latency, with an empty FIFO and no contention: an input pulse at edge N is captured into pending/holding; the grant and push happen at edge N+1; cmd_valid is high after edge N+1, i.e. 2 cycles.
- An input pulse in the same cycle its pending/holding entry is granted is captured as a new request, not coalesced.
- drop_cnt saturates at all-ones. Multiple drop events in one cycle add their count, with saturation.
- Reset mid-operation flushes the FIFO and all pending requests immediately; no partial command is issued.

Optional Feature:
- Macro: CMD_UPPERCASE_EN.
- Defined: UART decode also accepts 'R','S','C','M','U','D' with the same mapping as lowercase.
- Undefined: uppercase bytes are unknown, discarded, and increment drop_cnt.

Test Plan:
- Reset, then rx_valid with rx_data=8'h72 ('r'), cmd_ready=1 → cmd_valid=1, cmd_code=3, cmd_src=1 exactly 2 cycles later, for one cycle; fifo_level returns to 0.
- btn_clear, btn_run_stop and btn_mode pulsed in the same cycle, cmd_ready=0 → FIFO holds CLEAR(5), RUN_TOGGLE(2), MODE_TOGGLE(1) in that order; fifo_level=3.
- btn_mode and UART 'd' arrive in the same cycle after reset → button granted first: MODE_TOGGLE(src 0) then SET_DOWN(7, src 1).
- cmd_ready=0, 6 distinct requests with FIFO_DEPTH=4 → fifo_level=4, extra requests wait; after cmd_ready=1, all 6 issue in order with drop_cnt=0.
- UART bytes 'x', 'R' (macro undefined), then 2 back-to-back 'c' with the FIFO full → drop_cnt=3; 255+ drops hold drop_cnt=8'hFF.
- reset asserted with fifo_level=3 and a pending button → next cycle cmd_valid=0, fifo_level=0, and no command issues after reset release.

Source files
------------

// File: rtl/counter_cmd_arbiter.sv
// counter_cmd_arbiter
//   Merges debounced front-panel button pulses and decoded UART bytes into a
//   single ordered command stream for the 10 Hz up/down counter control unit.
//   Buttons keep one pending bit each (fixed priority clear > run_stop > mode);
//   UART has a one-entry holding register. A round-robin arbiter pushes at most
//   one command per cycle into a small FIFO, which is drained over a
//   valid/ready handshake.
//
// Ports
//   clk, reset       system clock, asynchronous active-high reset
//   btn_mode         one-cycle debounced pulse -> MODE_TOGGLE
//   btn_run_stop     one-cycle debounced pulse -> RUN_TOGGLE
//   btn_clear        one-cycle debounced pulse -> CLEAR
//   rx_data/rx_valid UART received byte and its qualifying strobe
//   cmd_valid        FIFO head valid
//   cmd_code         command at FIFO head (0 when empty)
//   cmd_src          origin of head command: 0 = button, 1 = UART
//   cmd_ready        consumer accepts the head command
//   fifo_level       current FIFO occupancy
//   drop_cnt         saturating count of discarded inputs
//
// Build option
//   CMD_UPPERCASE_EN  when defined, 'R','S','C','M','U','D' decode like their
//                     lowercase counterparts; otherwise they are dropped.

module counter_cmd_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn_mode,
  input  logic                          btn_run_stop,
  input  logic                          btn_clear,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          cmd_valid,
  output logic [2:0]                    cmd_code,
  output logic                          cmd_src,
  input  logic                          cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [2:0] CMD_MODE_TOGGLE = 3'd1;
  localparam logic [2:0] CMD_RUN_TOGGLE  = 3'd2;
  localparam logic [2:0] CMD_RUN         = 3'd3;
  localparam logic [2:0] CMD_STOP        = 3'd4;
  localparam logic [2:0] CMD_CLEAR       = 3'd5;
  localparam logic [2:0] CMD_SET_UP      = 3'd6;
  localparam logic [2:0] CMD_SET_DOWN    = 3'd7;

  localparam logic SRC_BTN  = 1'b0;
  localparam logic SRC_UART = 1'b1;

  // Returns {known, code}
  function automatic logic [3:0] decode_byte(input logic [7:0] b);
    logic [3:0] r;
    case (b)
      8'h72:   r = {1'b1, CMD_RUN};         // 'r'
      8'h73:   r = {1'b1, CMD_STOP};        // 's'
      8'h63:   r = {1'b1, CMD_CLEAR};       // 'c'
      8'h6D:   r = {1'b1, CMD_MODE_TOGGLE}; // 'm'
      8'h75:   r = {1'b1, CMD_SET_UP};      // 'u'
      8'h64:   r = {1'b1, CMD_SET_DOWN};    // 'd'
`ifdef CMD_UPPERCASE_EN
      8'h52:   r = {1'b1, CMD_RUN};         // 'R'
      8'h53:   r = {1'b1, CMD_STOP};        // 'S'
      8'h43:   r = {1'b1, CMD_CLEAR};       // 'C'
      8'h4D:   r = {1'b1, CMD_MODE_TOGGLE}; // 'M'
      8'h55:   r = {1'b1, CMD_SET_UP};      // 'U'
      8'h44:   r = {1'b1, CMD_SET_DOWN};    // 'D'
`endif
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Pending bits: [2] clear, [1] run_stop, [0] mode
  logic [2:0]    btn_pend;
  logic          hold_valid;
  logic [2:0]    hold_code;
  logic          last_grant;

  logic [3:0]    mem [FIFO_DEPTH];   // {src, code}
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic [2:0]    btn_pulse;
  logic [2:0]    btn_clr;
  logic [2:0]    btn_code;
  logic          btn_req;
  logic          uart_req;
  logic          full;
  logic          grant_btn;
  logic          grant_uart;
  logic          push;
  logic          pop;
  logic [3:0]    push_word;
  logic [3:0]    dec;
  logic          uart_load;
  logic          uart_drop;
  logic [2:0]    btn_drop;
  logic [2:0]    drop_inc;
  logic [DROP_W:0] drop_sum;

  assign btn_pulse = {btn_clear, btn_run_stop, btn_mode};
  assign btn_req   = |btn_pend;
  assign uart_req  = hold_valid;
  assign full      = (level == LW'(FIFO_DEPTH));
  assign cmd_valid = (level != '0);
  assign pop       = cmd_valid && cmd_ready;

  // Fixed priority among pending buttons
  always_comb begin
    btn_clr  = 3'b000;
    btn_code = 3'd0;
    if (btn_pend[2]) begin
      btn_clr  = 3'b100;
      btn_code = CMD_CLEAR;
    end else if (btn_pend[1]) begin
      btn_clr  = 3'b010;
      btn_code = CMD_RUN_TOGGLE;
    end else if (btn_pend[0]) begin
      btn_clr  = 3'b001;
      btn_code = CMD_MODE_TOGGLE;
    end
  end

  // Round robin: on contention the source not granted last time wins.
  // A full FIFO blocks the push even if a pop happens this cycle.
  assign grant_btn  = !full && btn_req  && (!uart_req || (last_grant == SRC_UART));
  assign grant_uart = !full && uart_req && (!btn_req  || (last_grant == SRC_BTN));
  assign push       = grant_btn || grant_uart;
  assign push_word  = grant_uart ? {SRC_UART, hold_code} : {SRC_BTN, btn_code};

  // A pulse on an entry being granted this cycle is a fresh request, not a drop
  assign btn_drop  = btn_pulse & btn_pend & ~(grant_btn ? btn_clr : 3'b000);
  assign dec       = decode_byte(rx_data);
  assign uart_load = rx_valid && dec[3] && (!hold_valid || grant_uart);
  assign uart_drop = rx_valid && !uart_load;

  assign drop_inc = 3'(btn_drop[0]) + 3'(btn_drop[1]) + 3'(btn_drop[2]) + 3'(uart_drop);
  assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(drop_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_pend   <= 3'b000;
      hold_valid <= 1'b0;
      hold_code  <= 3'd0;
      last_grant <= SRC_UART;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drop_cnt   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'b0000;
    end else begin
      btn_pend <= (btn_pend & ~(grant_btn ? btn_clr : 3'b000)) | btn_pulse;

      if (uart_load) begin
        hold_valid <= 1'b1;
        hold_code  <= dec[2:0];
      end else if (grant_uart) begin
        hold_valid <= 1'b0;
      end

      if (push) begin
        last_grant  <= grant_uart ? SRC_UART : SRC_BTN;
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (drop_sum[DROP_W]) drop_cnt <= '1;
      else                  drop_cnt <= drop_sum[DROP_W-1:0];
    end
  end

  assign fifo_level = level;
  assign cmd_code   = cmd_valid ? mem[rd_ptr][2:0] : 3'd0;
  assign cmd_src    = cmd_valid ? mem[rd_ptr][3]   : 1'b0;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench for counter_cmd_arbiter (FIFO_DEPTH=4, DROP_W=8).
module tb_counter_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_run_stop = 1'b0, btn_clear = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_src;
  logic       cmd_ready = 1'b0;
  logic [2:0] fifo_level;
  logic [7:0] drop_cnt;

  int passed = 0;
  int total  = 0;

  counter_cmd_arbiter #(.FIFO_DEPTH(4), .DROP_W(8)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_run_stop(btn_run_stop), .btn_clear(btn_clear),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_src(cmd_src),
    .cmd_ready(cmd_ready), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [2:0] code, input logic src);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, "_code"},  32'(cmd_code),  32'(code));
    chk({tag, "_src"},   32'(cmd_src),   32'(src));
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  logic [2:0] exp_code [6] = '{3'd5, 3'd6, 3'd2, 3'd4, 3'd1, 3'd7};
  logic       exp_src  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_code",  32'(cmd_code),  32'd0);
    chk("rst_src",   32'(cmd_src),   32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop",  32'(drop_cnt),  32'd0);
    reset = 1'b0;
    tick();

    // 'r' with cmd_ready=1: valid exactly 2 cycles after the strobe, one cycle
    cmd_ready = 1'b1;
    send(8'h72);
    chk("lat_n1_valid", 32'(cmd_valid), 32'd0);
    tick();
    head("lat_n2", 3'd3, 1'b1);
    chk("lat_n2_level", 32'(fifo_level), 32'd1);
    tick();
    chk("lat_n3_valid", 32'(cmd_valid), 32'd0);
    chk("lat_n3_level", 32'(fifo_level), 32'd0);

    // Three buttons in one cycle: priority order clear, run_stop, mode
    cmd_ready = 1'b0;
    btn_clear = 1'b1; btn_run_stop = 1'b1; btn_mode = 1'b1;
    tick();
    btn_clear = 1'b0; btn_run_stop = 1'b0; btn_mode = 1'b0;
    tick(); tick(); tick();
    chk("btn3_level", 32'(fifo_level), 32'd3);
    head("btn3_h0", 3'd5, 1'b0);
    tick();
    head("btn3_stall", 3'd5, 1'b0);
    cmd_ready = 1'b1;
    tick();
    head("btn3_h1", 3'd2, 1'b0);
    tick();
    head("btn3_h2", 3'd1, 1'b0);
    tick();
    chk("btn3_empty", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;

    // Contention right after reset: button wins first (last_grant=UART)
    reset = 1'b1; tick(); reset = 1'b0; tick();
    btn_mode = 1'b1;
    send(8'h64);
    btn_mode = 1'b0;
    tick(); tick();
    chk("rr_level", 32'(fifo_level), 32'd2);
    head("rr_h0", 3'd1, 1'b0);
    cmd_ready = 1'b1;
    tick();
    head("rr_h1", 3'd7, 1'b1);
    tick();
    chk("rr_empty", 32'(fifo_level), 32'd0);
    cmd_ready = 1'b0;

    // Six requests against a depth-4 FIFO; the last two wait, none dropped
    btn_clear = 1'b1; btn_run_stop = 1'b1; btn_mode = 1'b1;
    send(8'h75);
    btn_clear = 1'b0; btn_run_stop = 1'b0; btn_mode = 1'b0;
    tick();
    send(8'h73);          // loads as 'u' is granted
    tick(); tick();
    send(8'h64);
    tick();
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_drop",  32'(drop_cnt),   32'd0);
    cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      head($sformatf("ovf_h%0d", i), exp_code[i], exp_src[i]);
      tick();
    end
    chk("ovf_empty", 32'(cmd_valid), 32'd0);
    chk("ovf_drop2", 32'(drop_cnt),  32'd0);
    cmd_ready = 1'b0;

    // Fill FIFO with back-to-back UART bytes, then provoke drops
    send(8'h6D); send(8'h75); send(8'h64); send(8'h73);
    tick();
    chk("fill_level", 32'(fifo_level), 32'd4);
    send(8'h78);          // 'x' unknown
    chk("drop_x", 32'(drop_cnt), 32'd1);
    send(8'h52);          // 'R': unknown, or loads the holding register with the option
    send(8'h63);
    send(8'h63);
    chk("drop_c", 32'(drop_cnt), 32'd3);
    chk("drop_level", 32'(fifo_level), 32'd4);
    // Coalesced button and unknown byte in one cycle count two
    btn_clear = 1'b1; tick();
    rx_data = 8'h78; rx_valid = 1'b1; tick();
    btn_clear = 1'b0; rx_valid = 1'b0;
    chk("drop_multi", 32'(drop_cnt), 32'd5);
    for (int i = 0; i < 260; i++) send(8'h78);
    chk("drop_sat", 32'(drop_cnt), 32'hFF);
    send(8'h78);
    chk("drop_sat2", 32'(drop_cnt), 32'hFF);

    // Pop one so level=3 with button and UART still pending, then reset
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(cmd_valid), 32'd0);
    chk("async_rst_level", 32'(fifo_level), 32'd0);
    tick();
    chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_idle%0d", i), 32'(cmd_valid), 32'd0);
    end
    chk("post_rst_level", 32'(fifo_level), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
